fp_mult_arbiter: RTL

//  Shares one pipelined single-precision multiplier (fixed LATENCY, no stall) between NUM_REQ requesters.
//  - Round-robin grant of at most one operand pair per cycle.
//  - Registers the granted operands into the multiplier.
//  - Carries a requester tag alongside the multiplier pipeline and routes each product back to its issuer.
//  - Sits between accelerator lanes and the FP multiply core; a drain/halt FSM supports quiescing before reconfiguration.

---
 rtl/fp_mult_arb_pkg.sv | 25 ++
 rtl/fp_mult_arbiter_rr_arbiter.sv | 31 +++
 rtl/fp_mult_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fp_mult_arb_pkg.sv
// Shared types and helpers for the FP multiplier arbiter.
// Holds the fixed operand width, the drain/halt state encoding and a one-hot decoder.
package fp_mult_arb_pkg;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        HALTED,
        RUN,
        DRAIN
    } arb_state_t;

    // Returns the bit position of a one-hot vector (up to 8 requesters).
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oneHot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oneHot[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fp_mult_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Searches upward from ptrIn with wrap and returns the first active request.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  reqIn,
    input  logic [IW-1:0] ptrIn,
    output logic [N-1:0]  gntOut,
    output logic [IW-1:0] gntIdxOut,
    output logic          anyOut
);

    logic [IW-1:0] pos;

    always_comb begin
        gntOut    = '0;
        gntIdxOut = '0;
        anyOut    = 1'b0;
        pos       = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(ptrIn) + k) % N);
            if (!anyOut && reqIn[pos]) begin
                anyOut      = 1'b1;
                gntOut[pos] = 1'b1;
                gntIdxOut   = pos;
            end
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one fixed-latency pipelined FP multiplier between NUM_REQ requesters.
// Optional tag/valid consistency checker enabled by defining FP_MULT_ARB_CHECK_EN.
module fp_mult_arbiter
    import fp_mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 8
) (
    input  logic                          clkIn,
    input  logic                          rstIn,
    input  logic                          enableIn,
    input  logic [NUM_REQ-1:0]            reqValidIn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataAIn,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataBIn,
    output logic [NUM_REQ-1:0]            reqReadyOut,
    output logic [DATA_WIDTH-1:0]         mulDataAOut,
    output logic [DATA_WIDTH-1:0]         mulDataBOut,
    output logic                          mulValidOut,
    input  logic [DATA_WIDTH-1:0]         mulDataIn,
    input  logic                          mulValidIn,
    output logic [DATA_WIDTH-1:0]         rspDataOut,
    output logic [NUM_REQ-1:0]            rspValidOut,
    output logic                          idleOut,
    output logic                          errOut
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t            state;
    logic [IW-1:0]         rrPtr;
    logic                  grantEn;
    logic [NUM_REQ-1:0]    arbReq;
    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         gntIdx;
    logic                  anyGnt;
    logic [DATA_WIDTH-1:0] selA;
    logic [DATA_WIDTH-1:0] selB;
    logic [IW-1:0]         issueId;
    logic [LATENCY-1:0]    tagValid;
    logic [IW-1:0]         tagId [LATENCY];
    logic                  pipeEmpty;

    // Dropping enableIn stops granting in the same cycle, before the FSM leaves RUN.
    assign grantEn   = (state == RUN) && enableIn;
    assign arbReq    = grantEn ? reqValidIn : '0;
    assign pipeEmpty = (tagValid == '0);

    rr_arbiter #(.N(NUM_REQ)) uArb (
        .reqIn     (arbReq),
        .ptrIn     (rrPtr),
        .gntOut    (gnt),
        .gntIdxOut (gntIdx),
        .anyOut    (anyGnt)
    );

    assign reqReadyOut = gnt;
    assign selA = reqDataAIn[int'(gntIdx)*DATA_WIDTH +: DATA_WIDTH];
    assign selB = reqDataBIn[int'(gntIdx)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state   <= HALTED;
            idleOut <= 1'b1;
        end else begin
            case (state)
                HALTED: begin
                    if (enableIn) begin
                        state   <= RUN;
                        idleOut <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enableIn) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enableIn) begin
                        state <= RUN;
                    end else if (pipeEmpty && !mulValidOut) begin
                        state   <= HALTED;
                        idleOut <= 1'b1;
                    end
                end
                default: begin
                    state   <= HALTED;
                    idleOut <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            mulValidOut <= 1'b0;
            mulDataAOut <= '0;
            mulDataBOut <= '0;
            issueId     <= '0;
            rrPtr       <= '0;
        end else begin
            mulValidOut <= anyGnt;
            if (anyGnt) begin
                mulDataAOut <= selA;
                mulDataBOut <= selB;
                issueId     <= IW'(onehot_to_idx(8'(gnt)));
                rrPtr       <= (gntIdx == IW'(NUM_REQ - 1)) ? '0 : gntIdx + IW'(1);
            end
        end
    end

    // The last tag stage lines up with the product emerging from the core.
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            for (int i = 0; i < LATENCY; i++) begin
                tagValid[i] <= 1'b0;
                tagId[i]    <= '0;
            end
        end else begin
            tagValid[0] <= mulValidOut;
            tagId[0]    <= issueId;
            for (int i = 1; i < LATENCY; i++) begin
                tagValid[i] <= tagValid[i-1];
                tagId[i]    <= tagId[i-1];
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            rspDataOut  <= '0;
            rspValidOut <= '0;
        end else if (tagValid[LATENCY-1]) begin
            rspDataOut  <= mulDataIn;
            rspValidOut <= {{(NUM_REQ-1){1'b0}}, 1'b1} << tagId[LATENCY-1];
        end else begin
            rspValidOut <= '0;
        end
    end

`ifdef FP_MULT_ARB_CHECK_EN
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            errOut <= 1'b0;
        end else if (mulValidIn != tagValid[LATENCY-1]) begin
            errOut <= 1'b1;
        end
    end
`else
    logic unusedMulValid;
    assign unusedMulValid = mulValidIn;
    assign errOut         = 1'b0;
`endif

endmodule
